// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_DWORD = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_HALF  = 2'b10,
        SZ_BYTE  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_MERGE,
        ST_WRITE,
        ST_RESP,
        ST_ERR
    } state_t;

    function automatic logic is_misaligned(input size_t size, input logic [2:0] offset);
        logic bad;
        case (size)
            SZ_DWORD: bad = (offset != 3'd0);
            SZ_WORD:  bad = (offset[1:0] != 2'd0);
            SZ_HALF:  bad = offset[0];
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts and extends a load lane from a dword, and
// builds the dword written back by a sub-dword store. Memory is little-endian.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  size_t       size,
    input  logic        is_unsigned,
    output logic [63:0] extended,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] lane_mask;

    always_comb begin
        shamt     = {offset, 3'b000};
        shifted   = rdata >> shamt;
        extended  = rdata;
        lane_mask = '1;
        case (size)
            SZ_BYTE: begin
                lane_mask = 64'h0000_0000_0000_00FF;
                extended  = is_unsigned ? {56'b0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_mask = 64'h0000_0000_0000_FFFF;
                extended  = is_unsigned ? {48'b0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                lane_mask = 64'h0000_0000_FFFF_FFFF;
                extended  = is_unsigned ? {32'b0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                lane_mask = '1;
                extended  = rdata;
            end
        endcase
        merged = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder between the control FSM and a 64-bit synchronous data
// memory: sized loads with extension, read-modify-write sub-dword stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [63:0] dmem_rdata,
    output state_t      dbg_state
);

    // Handshake: a request is taken on any rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE. The response is
    // a one-cycle resp_valid pulse with no backpressure.

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic        r_write;
    size_t       r_size;
    logic        r_unsigned;
    logic [2:0]  r_offset;
    logic [63:0] r_wdata;
    logic [63:0] lane_extended;
    logic [63:0] lane_merged;
    size_t       in_size;

    assign in_size   = size_t'(req_size);
    assign dbg_state = state;

    byte_lane_unit u_lanes (
        .rdata       (dmem_rdata),
        .wdata       (r_wdata),
        .offset      (r_offset),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .extended    (lane_extended),
        .merged      (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            r_write    <= 1'b0;
            r_size     <= SZ_DWORD;
            r_unsigned <= 1'b0;
            r_offset   <= '0;
            r_wdata    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            dmem_we    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_write    <= req_write;
                        r_size     <= in_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_addr[2:0];
                        r_wdata    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (is_misaligned(in_size, req_addr[2:0])) begin
                            state      <= ST_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_write && in_size == SZ_DWORD) begin
                            // Full-dword store needs no read: write straight away.
                            state      <= ST_WRITE;
                            dmem_addr  <= {req_addr[63:3], 3'b000};
                            dmem_wdata <= req_wdata;
                            dmem_we    <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            lat_cnt   <= '0;
                            dmem_addr <= {req_addr[63:3], 3'b000};
                        end
                    end
                end
                ST_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= r_write ? ST_MERGE : ST_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    resp_rdata <= lane_extended;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_MERGE: begin
                    dmem_wdata <= lane_merged;
                    dmem_we    <= 1'b1;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP, ST_ERR: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each attached to its own little-endian memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
        logic [31:0] due;
    } resp_exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [31:0] due;
    } we_exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic [63:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic        resp_valid [2];
    logic        resp_err [2];
    logic [63:0] resp_rdata [2];
    logic [63:0] dmem_addr [2];
    logic [63:0] dmem_wdata [2];
    logic        dmem_we [2];
    logic [63:0] dmem_rdata [2];
    state_t      dbg_state [2];

    logic [63:0] mem0 [0:7] = '{64'h0, 64'h0, 64'h1122_3344_8899_AABB, 64'h0,
                                64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] mem1 [0:7] = '{64'h0, 64'h0, 64'h1122_3344_8899_AABB, 64'h0,
                                64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] pipe1_a, pipe1_b;

    resp_exp_t   rq0[$], rq1[$];
    we_exp_t     wq0[$], wq1[$];
    logic [63:0] last_rd [2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and memory models ----------------
    mem_access_unit #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_err(resp_err[0]),
        .resp_rdata(resp_rdata[0]), .dmem_addr(dmem_addr[0]), .dmem_wdata(dmem_wdata[0]),
        .dmem_we(dmem_we[0]), .dmem_rdata(dmem_rdata[0]), .dbg_state(dbg_state[0])
    );

    mem_access_unit #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_err(resp_err[1]),
        .resp_rdata(resp_rdata[1]), .dmem_addr(dmem_addr[1]), .dmem_wdata(dmem_wdata[1]),
        .dmem_we(dmem_we[1]), .dmem_rdata(dmem_rdata[1]), .dbg_state(dbg_state[1])
    );

    always @(posedge clk) begin
        dmem_rdata[0] <= mem0[dmem_addr[0][5:3]];
        if (dmem_we[0]) mem0[dmem_addr[0][5:3]] <= dmem_wdata[0];
    end

    always @(posedge clk) begin
        pipe1_a       <= mem1[dmem_addr[1][5:3]];
        pipe1_b       <= pipe1_a;
        dmem_rdata[1] <= pipe1_b;
        if (dmem_we[1]) mem1[dmem_addr[1][5:3]] <= dmem_wdata[1];
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int i);
        n_checks++;
        n_fail++;
        $display("FAIL %s u%0d: unexpected event at cycle %0d, none expected", name, i, cyc);
    endtask

    task automatic mon_resp(input int i);
        resp_exp_t e;
        if (resp_valid[i] !== 1'b1) return;
        if ((i == 0 && rq0.size() == 0) || (i == 1 && rq1.size() == 0)) begin
            unexpected("resp_valid", i);
            return;
        end
        if (i == 0) e = rq0.pop_front();
        else        e = rq1.pop_front();
        check($sformatf("resp_err u%0d", i), 64'(resp_err[i]), 64'(e.err));
        check($sformatf("resp_rdata u%0d", i), resp_rdata[i], e.rdata);
        check($sformatf("resp_cycle u%0d", i), 64'(cyc), 64'(e.due));
    endtask

    task automatic mon_we(input int i);
        we_exp_t e;
        if (dmem_we[i] !== 1'b1) return;
        if ((i == 0 && wq0.size() == 0) || (i == 1 && wq1.size() == 0)) begin
            unexpected("dmem_we", i);
            return;
        end
        if (i == 0) e = wq0.pop_front();
        else        e = wq1.pop_front();
        check($sformatf("dmem_addr u%0d", i), dmem_addr[i], e.addr);
        check($sformatf("dmem_wdata u%0d", i), dmem_wdata[i], e.wdata);
        check($sformatf("we_cycle u%0d", i), 64'(cyc), 64'(e.due));
    endtask

    always @(negedge clk) begin
        mon_resp(0);
        mon_resp(1);
        mon_we(0);
        mon_we(1);
    end

    // ---------------- driver ----------------
    // Called at a negedge. Expected event times are absolute negedge cycle
    // numbers: an event "at T+k" is visible at the negedge where cyc == T+k-1.
    task automatic issue(input int i, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic err,
                         input logic [63:0] ld_val, input logic [63:0] mem_val,
                         input logic drop);
        int        guard = 0;
        int        t;
        int        extra;
        int        resp_k;
        int        we_k;
        resp_exp_t re;
        we_exp_t   we;
        while (req_ready[i] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) unexpected("req_ready_timeout", i);
        req_valid[i]    = 1'b1;
        req_write[i]    = wr;
        req_size[i]     = sz;
        req_unsigned[i] = uns;
        req_addr[i]     = addr;
        req_wdata[i]    = wd;
        t      = cyc + 1;
        extra  = (i == 1) ? 2 : 0;
        we_k   = 0;
        if (err)                        resp_k = 1;
        else if (wr && sz == SZ_DWORD) begin we_k = 1; resp_k = 2; end
        else if (wr)                    begin we_k = 3 + extra; resp_k = 4 + extra; end
        else                            resp_k = 3 + extra;
        if (we_k != 0) begin
            we.addr  = {addr[63:3], 3'b000};
            we.wdata = mem_val;
            we.due   = 32'(t + we_k - 1);
            if (i == 0) wq0.push_back(we);
            else        wq1.push_back(we);
        end
        if (!drop) begin
            if (!wr && !err) last_rd[i] = ld_val;
            re.err   = err;
            re.rdata = last_rd[i];
            re.due   = 32'(t + resp_k - 1);
            if (i == 0) rq0.push_back(re);
            else        rq1.push_back(re);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
            req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst req_ready", 64'(req_ready[0]), 64'd1);
        check("rst resp_valid", 64'(resp_valid[0]), 64'd0);
        check("rst resp_err", 64'(resp_err[0]), 64'd0);
        check("rst resp_rdata", resp_rdata[0], 64'd0);
        check("rst dmem_we", 64'(dmem_we[0]), 64'd0);
        check("rst dmem_addr", dmem_addr[0], 64'd0);
        check("rst dmem_wdata", dmem_wdata[0], 64'd0);
        check("rst state", 64'(dbg_state[0]), 64'(ST_IDLE));
        Reset = 1'b1;
        @(negedge clk);

        // loads, MEM_LAT=1
        issue(0, 0, SZ_BYTE,  0, 64'h11, 0, 0, 64'hFFFF_FFFF_FFFF_FFAA, 0, 0);
        issue(0, 0, SZ_BYTE,  1, 64'h11, 0, 0, 64'h0000_0000_0000_00AA, 0, 0);
        issue(0, 0, SZ_HALF,  0, 64'h12, 0, 0, 64'hFFFF_FFFF_FFFF_8899, 0, 0);
        issue(0, 0, SZ_WORD,  1, 64'h14, 0, 0, 64'h0000_0000_1122_3344, 0, 0);
        issue(0, 0, SZ_WORD,  0, 64'h10, 0, 0, 64'hFFFF_FFFF_8899_AABB, 0, 0);
        issue(0, 0, SZ_BYTE,  1, 64'h17, 0, 0, 64'h0000_0000_0000_0011, 0, 0);
        issue(0, 0, SZ_DWORD, 0, 64'h10, 0, 0, 64'h1122_3344_8899_AABB, 0, 0);
        // stores
        issue(0, 1, SZ_BYTE,  0, 64'h13, 64'hFFFF_FFFF_FFFF_FF55, 0, 0, 64'h1122_3344_5599_AABB, 0);
        issue(0, 0, SZ_DWORD, 0, 64'h10, 0, 0, 64'h1122_3344_5599_AABB, 0, 0);
        issue(0, 1, SZ_DWORD, 0, 64'h18, 64'hDEAD_BEEF_0000_0001, 0, 0, 64'hDEAD_BEEF_0000_0001, 0);
        issue(0, 1, SZ_HALF,  0, 64'h1E, 64'h0000_0000_0000_CAFE, 0, 0, 64'hCAFE_BEEF_0000_0001, 0);
        issue(0, 1, SZ_WORD,  0, 64'h18, 64'hFFFF_FFFF_AABB_CCDD, 0, 0, 64'hCAFE_BEEF_AABB_CCDD, 0);
        issue(0, 0, SZ_DWORD, 0, 64'h18, 0, 0, 64'hCAFE_BEEF_AABB_CCDD, 0, 0);
        // misaligned
        issue(0, 1, SZ_HALF,  0, 64'h11, 64'h1234, 1, 0, 0, 0);
        issue(0, 0, SZ_WORD,  0, 64'h16, 0, 1, 0, 0, 0);
        issue(0, 0, SZ_DWORD, 0, 64'h14, 0, 1, 0, 0, 0);
        issue(0, 0, SZ_DWORD, 0, 64'h10, 0, 0, 64'h1122_3344_5599_AABB, 0, 0);

        // reset while a load sits in READ: no response, back to IDLE
        issue(0, 0, SZ_DWORD, 0, 64'h10, 0, 0, 0, 0, 1);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        check("midrst req_ready", 64'(req_ready[0]), 64'd1);
        check("midrst resp_valid", 64'(resp_valid[0]), 64'd0);
        check("midrst resp_rdata", resp_rdata[0], 64'd0);
        repeat (5) @(negedge clk);
        issue(0, 0, SZ_HALF,  1, 64'h16, 0, 0, 64'h0000_0000_0000_1122, 0, 0);

        // reset during WRITE: the write commits, the response is lost
        issue(0, 1, SZ_DWORD, 0, 64'h20, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0123_4567_89AB_CDEF, 1);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        last_rd[0] = '0;
        check("wrrst req_ready", 64'(req_ready[0]), 64'd1);
        check("wrrst dmem_we", 64'(dmem_we[0]), 64'd0);
        repeat (3) @(negedge clk);
        issue(0, 0, SZ_DWORD, 0, 64'h20, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0);

        // MEM_LAT=3 instance: same load data, two extra cycles of latency
        issue(1, 0, SZ_BYTE,  0, 64'h11, 0, 0, 64'hFFFF_FFFF_FFFF_FFAA, 0, 0);
        issue(1, 0, SZ_BYTE,  1, 64'h11, 0, 0, 64'h0000_0000_0000_00AA, 0, 0);
        issue(1, 0, SZ_HALF,  0, 64'h12, 0, 0, 64'hFFFF_FFFF_FFFF_8899, 0, 0);
        issue(1, 0, SZ_WORD,  1, 64'h14, 0, 0, 64'h0000_0000_1122_3344, 0, 0);
        issue(1, 1, SZ_BYTE,  0, 64'h13, 64'h55, 0, 0, 64'h1122_3344_5599_AABB, 0);
        issue(1, 0, SZ_DWORD, 0, 64'h10, 0, 0, 64'h1122_3344_5599_AABB, 0, 0);
        issue(1, 0, SZ_WORD,  0, 64'h12, 0, 1, 0, 0, 0);

        g = 0;
        while ((rq0.size() + rq1.size() + wq0.size() + wq1.size()) != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("pending expectations", 64'(rq0.size() + rq1.size() + wq0.size() + wq1.size()), 64'd0);
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder that services load/store requests issued by the multicycle control FSM.
- Supports byte, half, word and doubleword sizes, with sign/zero extension on loads and read-modify-write for sub-doubleword stores.
- Flags misaligned accesses instead of touching memory.
- Sits between the control unit/datapath (MDR, ALUOut, RegB) and the 64-bit synchronous data memory.

Parameters:
- MEM_LAT, 1, data-memory read latency in cycles (dmem_rdata valid MEM_LAT cycles after address presented); legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  access size: 00 = dword, 01 = word, 10 = half, 11 = byte
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  64  byte address (ALUOut)
- req_wdata  in  64  store data; low 8/16/32/64 bits used
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned access; valid with resp_valid
- resp_rdata  out  64  extended load data; held stable until next accept
- dmem_addr  out  64  dword-aligned address {req_addr[63:3],3'b000}
- dmem_wdata  out  64  full dword to write
- dmem_we  out  1  single-cycle write strobe
- dmem_rdata  in  64  memory read data

Behaviour:
- **Reset (Reset=0 at edge):**
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, latency counter=0.
- **Accept:** on an edge with req_valid & req_ready (cycle T), latch write, size, unsigned, addr and wdata. The request bus is ignored outside IDLE.
- **Alignment rules:**
  - dword requires addr[2:0]=0; word requires addr[1:0]=0; half requires addr[0]=0; byte is always aligned.
  - Lane offset = addr[2:0].
- **FSM states:** IDLE, READ, CAPTURE, MERGE, WRITE, RESP, ERR.
  - IDLE -> ERR if misaligned; -> WRITE if store dword; -> READ otherwise.
  - READ: drive dmem_addr for MEM_LAT cycles (counter), then -> CAPTURE (load) or MERGE (store).
  - CAPTURE: register dmem_rdata, extract lane, sign/zero extend into resp_rdata -> RESP.
  - MERGE: register dmem_rdata with the selected lane replaced by wdata low bits -> WRITE.
  - WRITE: dmem_we=1 for exactly one cycle with dmem_wdata -> RESP.
  - RESP: resp_valid=1, resp_err=0 -> IDLE.
  - ERR: resp_valid=1, resp_err=1, no dmem_we -> IDLE.
- **Latency (MEM_LAT=1):**
  - load: resp_valid at T+3
  - dword store: dmem_we at T+1, resp_valid at T+2
  - sub-dword store: dmem_we at T+3, resp_valid at T+4
  - misaligned: resp_valid at T+1
  - General form: each extra MEM_LAT cycle adds one cycle to the load and sub-dword-store paths.
- **Response handshake:** no backpressure; resp_valid is a single-cycle pulse. resp_rdata is unchanged for stores and errors.
- **Back-to-back requests:** req_ready rises in the cycle after RESP/ERR. A request held high during RESP is accepted on the following edge.
- **Byte lanes:** memory is little-endian; byte k of the dword is bits [8k+7:8k].
- **Reset mid-operation:** return to IDLE on that edge and drop dmem_we; no response is issued.
  - If Reset is low during the WRITE cycle, the memory still samples that write at the same edge (the write commits); the response is lost.
- dmem_we is never asserted outside WRITE.

Decomposition:
- **mem_access_pkg:**
  - size enum (SZ_DWORD, SZ_WORD, SZ_HALF, SZ_BYTE)
  - FSM state enum
  - function is_misaligned(size, addr[2:0])
- **byte_lane_unit:** combinational sub-module.
  - Extract+extend path: rdata, offset, size, unsigned -> extended.
  - Merge path: rdata, wdata, offset, size -> merged.
  - Instantiated once; the FSM registers its outputs in CAPTURE/MERGE.

Test Plan:
- **Setup:** preload mem[0x10] = 0x1122_3344_8899_AABB.
- **Byte loads:** load byte signed @0x11 -> resp_rdata = 0xFFFF_FFFF_FFFF_FFAA at T+3. Same with unsigned -> 0x0000_0000_0000_00AA.
- **Half/word loads:** load half signed @0x12 -> 0xFFFF_FFFF_FFFF_8899. Load word unsigned @0x14 -> 0x0000_0000_1122_3344.
- **Byte store (RMW):** store byte @0x13 wdata 0x55 -> one dmem_we at T+3 with dmem_wdata = 0x1122_3344_5599_AABB. Dword read-back returns that value.
- **Dword store:** store dword @0x18 wdata 0xDEAD_BEEF_0000_0001 -> dmem_we at T+1, no read cycle, resp_valid at T+2, resp_err = 0.
- **Misaligned:** store half @0x11 -> resp_valid & resp_err at T+1, dmem_we never asserted, memory unchanged. Load word @0x16 -> same error response.
- **Reset and latency:** Reset=0 during READ of a load -> next cycle req_ready=1, resp_valid=0. Rerun the load suite with MEM_LAT=3 -> load resp at T+5, identical data.
